regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Multi-port register file for the datapath: NUM_RD combinational read ports and NUM_WR write ports.
//  Optional write-to-read bypass and an optional hardwired-zero register 0.
//  A per-register busy scoreboard lets the hazard unit stall readers of registers with pending writes.
//  Sits between decode (reads, marks) and writeback (writes).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD    2   number of read ports (>=1)
//  NUM_WR    1   number of write ports (>=1)
//  ZERO_REG  1   1: reg 0 reads 0, ignores writes, never goes busy
//  BYPASS    1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clk        in   1                clock, rising edge
//  rst        in   1                asynchronous, active-high reset
//  rd_addr    in   NUM_RD*ADDR_W    read addresses; port k = [k*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*DATA_W    read data, port k = [k*DATA_W +: DATA_W]
//  rd_busy    out  NUM_RD           1 = register at rd_addr[k] is marked pending
//  wr_en      in   NUM_WR           write enable per write port
//  wr_addr    in   NUM_WR*ADDR_W    write addresses
//  wr_data    in   NUM_WR*DATA_W    write data
//  mark_en    in   1                set busy bit of mark_addr (producer issued)
//  mark_addr  in   ADDR_W           register to mark pending
//  busy_vec   out  2**ADDR_W        full scoreboard, bit i = reg i busy
// BEHAVIOUR
//  - Reset (async, rst=1): all registers = 0, all busy bits = 0 immediately; writes and marks ignored while rst=1.
//    Outputs during reset: rd_data=0, rd_busy=0, busy_vec=0.
//  - Write: on posedge clk, each port j with wr_en[j] stores wr_data[j] to wr_addr[j].
//    Latency 1 cycle to storage.
//  - Write collision (two ports, same addr, same cycle): the highest-index port wins, for both storage and bypass.
//  - Read: combinational from rd_addr, 0-cycle latency, with no clock dependency.
//  - BYPASS=1: if any enabled write port targets rd_addr[k] this cycle, rd_data[k] = that wr_data (collision rule applies).
//    BYPASS=0: rd_data[k] shows the old value until after the edge.
//  - ZERO_REG=1: address 0 always reads 0 (including bypass), writes to 0 are dropped,
//    marks to 0 are dropped, and busy_vec[0] is held at 0.
//  - Scoreboard, per register, on posedge clk:
//    - a write to the register clears its busy bit;
//    - mark_en sets it;
//    - simultaneous write and mark on the same register: the mark wins (busy=1, new producer), and the data is still written.
//  - rd_busy[k] = busy_vec[rd_addr[k]] registered state.
//    It is not bypassed; a clearing write becomes visible the next cycle.
//  - A mark on an already-busy register leaves it busy; a write to a non-busy register leaves it 0.
//  - Widths: no truncation or extension; all addresses are in range by construction (DEPTH = 2**ADDR_W).
//  - rst asserted mid-write: the reset result takes precedence and the write is lost.
// TESTING
//  1. Reset, then read all 32 regs on both ports -> every rd_data = 0, busy_vec = 0.
//  2. Write 0xDEADBEEF to r5, read r5 next cycle -> 0xDEADBEEF; same-cycle read with BYPASS=1 -> 0xDEADBEEF.
//  3. ZERO_REG=1: write 0x1234 to r0 plus mark r0 -> r0 reads 0, busy_vec[0] = 0.
//  4. NUM_WR=2: port0 writes 0x11 and port1 writes 0x22 to r7 in one cycle -> r7 = 0x22, bypass shows 0x22.
//  5. Mark r3 -> rd_busy=1 next cycle. Write r3 while marking r3 -> stays busy. Write r3 alone -> busy clears the cycle after.
//  6. Write r9 = 0xA5A5A5A5, mark r9, pulse rst asynchronously between edges -> r9 reads 0 and busy_vec = 0 at once.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass, hardwired-zero r0
// and a per-register busy scoreboard for the hazard unit.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       mark_en,
  input  logic [ADDR_W-1:0]          mark_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] wdat [DEPTH];
  logic [DEPTH-1:0]  wen;
  logic [DEPTH-1:0]  mark_hit;
  logic [DEPTH-1:0]  busy;

  // Per-register write decode; ascending port scan lets the highest index win.
  always_comb begin
    wen      = '0;
    mark_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wdat[i] = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
          wen[i]  = 1'b1;
          wdat[i] = wr_data[j*DATA_W +: DATA_W];
        end
      end
      mark_hit[i] = mark_en && (mark_addr == ADDR_W'(i));
      if (ZERO_REG != 0 && i == 0) begin
        wen[i]      = 1'b0;
        mark_hit[i] = 1'b0;
      end
    end
  end

  // Storage and scoreboard; a mark outranks a same-cycle write on the busy bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen[i]) mem[i] <= wdat[i];
        if (mark_hit[i])  busy[i] <= 1'b1;
        else if (wen[i])  busy[i] <= 1'b0;
      end
    end
  end

  assign busy_vec = rst ? '0 : busy;

  // Combinational read ports; busy is deliberately not bypassed.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = mem[a];
      if (BYPASS != 0 && wen[a]) d = wdat[a];
      if ((ZERO_REG != 0 && a == '0) || rst) d = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k] = !rst && busy[a];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read, 2 write ports, zero reg, bypass on).
// Expectations are queued by the stimulus and checked by a negedge monitor.
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     mark_en;
  logic [ADDR_W-1:0]        mark_addr;
  logic [31:0]              busy_vec;

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mark_en(mark_en), .mark_addr(mark_addr),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // sel: 0 = rd_data port0, 1 = rd_data port1, 2 = rd_busy port0,
  //      3 = rd_busy port1, 4 = busy_vec
  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        0:       act = rd_data[31:0];
        1:       act = rd_data[63:32];
        2:       act = {31'b0, rd_busy[0]};
        3:       act = {31'b0, rd_busy[1]};
        default: act = busy_vec;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = '0;
    mark_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                    input logic [4:0] a1, input logic [31:0] d1);
    wr_en   = en;
    wr_addr = {a1, a0};
    wr_data = {d1, d0};
  endtask

  task automatic mark(input logic [4:0] a);
    mark_en   = 1'b1;
    mark_addr = a;
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    mark_en = 1'b0; mark_addr = '0;
    step();
    expect_val("reset_rd0", 0, 32'h0);
    expect_val("reset_vec", 4, 32'h0);
    step();
    rst = 1'b0;

    // 1: every register reads zero after reset on both ports
    for (int r = 0; r < 32; r++) begin
      step();
      rd(5'(r), 5'(31 - r));
      expect_val("init_rd0", 0, 32'h0);
      expect_val("init_rd1", 1, 32'h0);
      expect_val("init_busy0", 2, 32'h0);
    end
    expect_val("init_vec", 4, 32'h0);

    // 2: write r5, bypass in the same cycle, stored value next cycle
    step();
    wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    rd(5'd5, 5'd6);
    expect_val("r5_bypass", 0, 32'hDEADBEEF);
    expect_val("r6_untouched", 1, 32'h0);
    step(); idle();
    expect_val("r5_stored", 0, 32'hDEADBEEF);

    // 3: r0 ignores writes and marks
    step();
    wr(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0);
    mark(5'd0);
    rd(5'd0, 5'd5);
    expect_val("r0_bypass_zero", 0, 32'h0);
    step(); idle();
    expect_val("r0_stored_zero", 0, 32'h0);
    expect_val("r0_busy", 2, 32'h0);
    expect_val("r0_vec", 4, 32'h0);

    // 4: collision, port1 wins; then port1 alone
    step();
    wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
    rd(5'd7, 5'd5);
    expect_val("r7_bypass_coll", 0, 32'h22);
    step(); idle();
    expect_val("r7_stored_coll", 0, 32'h22);
    expect_val("r5_kept", 1, 32'hDEADBEEF);
    step();
    wr(2'b10, 5'd0, 32'h0, 5'd12, 32'h00C0FFEE);
    rd(5'd7, 5'd12);
    expect_val("r12_bypass_p1", 1, 32'h00C0FFEE);
    step(); idle();
    expect_val("r12_stored_p1", 1, 32'h00C0FFEE);

    // 5: scoreboard on r3
    step();
    mark(5'd3);
    rd(5'd3, 5'd3);
    expect_val("r3_busy_before", 2, 32'h0);
    step(); idle();
    expect_val("r3_busy_marked", 2, 32'h1);
    expect_val("r3_busy_p1", 3, 32'h1);
    expect_val("r3_vec", 4, 32'h0000_0008);
    step();
    wr(2'b01, 5'd3, 32'h33, 5'd0, 32'h0);
    mark(5'd3);
    step(); idle();
    expect_val("r3_busy_mark_wins", 2, 32'h1);
    expect_val("r3_data_mark_write", 0, 32'h33);
    step();
    wr(2'b01, 5'd3, 32'h44, 5'd0, 32'h0);
    expect_val("r3_busy_not_bypassed", 2, 32'h1);
    expect_val("r3_data_bypass", 0, 32'h44);
    step(); idle();
    expect_val("r3_busy_cleared", 2, 32'h0);
    expect_val("r3_vec_cleared", 4, 32'h0);
    step();
    wr(2'b01, 5'd3, 32'h55, 5'd0, 32'h0);
    step(); idle();
    expect_val("r3_nonbusy_write", 2, 32'h0);

    // 6: async reset between edges clears data and scoreboard
    step();
    wr(2'b01, 5'd9, 32'hA5A5A5A5, 5'd0, 32'h0);
    mark(5'd9);
    rd(5'd9, 5'd5);
    step(); idle();
    expect_val("r9_stored", 0, 32'hA5A5A5A5);
    expect_val("r9_busy", 2, 32'h1);
    expect_val("r9_vec", 4, 32'h0000_0200);
    step();
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    expect_val("r9_async_clear", 0, 32'h0);
    expect_val("r5_async_clear", 1, 32'h0);
    expect_val("vec_async_clear", 4, 32'h0);
    expect_val("r9_busy_async", 2, 32'h0);
    // a write held across an edge while rst is high is lost
    step();
    rst = 1'b1;
    wr(2'b01, 5'd9, 32'h77, 5'd0, 32'h0);
    mark(5'd9);
    step();
    rst = 1'b0; idle();
    expect_val("r9_write_in_reset", 0, 32'h0);
    expect_val("r9_mark_in_reset", 2, 32'h0);

    begin
      int budget = 100;
      while (q.size() > 0 && budget > 0) begin
        step();
        budget--;
      end
      if (q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
    end
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
